// File: rtl/traffic_pkg.sv
// Shared light encoding, departure-FSM states and light-sequence helpers
// for the traffic_sensor intersection model.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CROSS = 1'b1
    } dep_state_t;

    // The illegal code 2'b11 never counts as green.
    function automatic logic is_green(input logic [1:0] code);
        return code == GREEN;
    endfunction

    // Light steps a real controller must never take.
    function automatic logic illegal_step(input logic [1:0] prev, input logic [1:0] cur);
        return (prev == GREEN && cur == RED) || (prev == RED && cur == YELLOW);
    endfunction

endpackage

// File: rtl/street_queue.sv
// One street of the intersection: a car counter fed by arrivals, a departure
// FSM that retires one car per DWELL green cycles, and a sticky overflow flag.
module street_queue
    import traffic_pkg::*;
#(
    parameter int QW    = 4,
    parameter int DWELL = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arr,
    input  logic [1:0]    light,
    output logic [QW-1:0] q,
    output logic          t,
    output logic          dep,
    output logic          ovf
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    dep_state_t    state;
    logic [CW-1:0] cnt;
    logic          green;
    logic          full;
    logic          do_dep;
    logic          ovf_set;
    logic [QW-1:0] q_next;

    assign green   = is_green(light);
    assign full    = (q == {QW{1'b1}});
    assign do_dep  = (state == CROSS) && green && (cnt == CNT_LAST);
    assign ovf_set = arr && !do_dep && full;
    assign t       = (q != '0);

    // A departure and an arrival in the same cycle cancel out.
    always_comb begin
        // NOTE: default first so every path assigns q_next; otherwise a latch is inferred.
        q_next = q;
        if (arr && !do_dep && !full)
            q_next = q + 1'b1;
        else if (!arr && do_dep)
            q_next = q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            dep   <= 1'b0;
            ovf   <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            q   <= q_next;
            dep <= do_dep;
            ovf <= ovf | ovf_set;
            case (state)
                IDLE: begin
                    if (green && q != '0) begin
                        state <= CROSS;
                        cnt   <= '0;
                    end
                end
                CROSS: begin
                    if (!green) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (do_dep) begin
                        cnt   <= '0;
                        state <= (q_next != '0) ? CROSS : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/traffic_sensor.sv
// Intersection environment model: two independent street queues plus an
// optional light-sequence safety monitor enabled by TRAFFIC_SENSOR_CHECK_EN.
module traffic_sensor
    import traffic_pkg::*;
#(
    parameter int QW    = 4,
    parameter int DWELL = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arr_a,
    input  logic          arr_b,
    input  logic [1:0]    la,
    input  logic [1:0]    lb,
    output logic          ta,
    output logic          tb,
    output logic [QW-1:0] qa,
    output logic [QW-1:0] qb,
    output logic          dep_a,
    output logic          dep_b,
    output logic          ovf_a,
    output logic          ovf_b,
    output logic          err
);

    street_queue #(.QW(QW), .DWELL(DWELL)) u_street_a (
        .clk   (clk),
        .reset (reset),
        .arr   (arr_a),
        .light (la),
        .q     (qa),
        .t     (ta),
        .dep   (dep_a),
        .ovf   (ovf_a)
    );

    street_queue #(.QW(QW), .DWELL(DWELL)) u_street_b (
        .clk   (clk),
        .reset (reset),
        .arr   (arr_b),
        .light (lb),
        .q     (qb),
        .t     (tb),
        .dep   (dep_b),
        .ovf   (ovf_b)
    );

`ifdef TRAFFIC_SENSOR_CHECK_EN
    logic [1:0] prev_la;
    logic [1:0] prev_lb;
    logic       err_q;
    logic       violation;

    assign violation = ((la != RED) && (lb != RED))
                     || (la == 2'b11) || (lb == 2'b11)
                     || illegal_step(prev_la, la)
                     || illegal_step(prev_lb, lb);

    // Previous lights start at RED so a legal RED->GREEN start is not flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_la <= RED;
            prev_lb <= RED;
            err_q   <= 1'b0;
        end else begin
            prev_la <= la;
            prev_lb <= lb;
            err_q   <= err_q | violation;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_sensor.sv
// Self-checking bench for traffic_sensor: vector table through a scoreboard
// queue, plus hand-written overflow and safety-monitor sequences.
module tb_traffic_sensor;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;

`ifdef TRAFFIC_SENSOR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       aa;
        logic       ab;
        logic [1:0] la;
        logic [1:0] lb;
        logic [3:0] eqa;
        logic [3:0] eqb;
        logic       edep_a;
        logic       edep_b;
        logic       eovf_a;
        logic       eovf_b;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       arr_a, arr_b;
    logic [1:0] la, lb;
    logic       ta, tb, dep_a, dep_b, ovf_a, ovf_b, err;
    logic [3:0] qa, qb;

    int n_compared   = 0;
    int n_mismatched = 0;
    vec_t sb[$];
    vec_t tbl[30];

    traffic_sensor #(.QW(4), .DWELL(2)) dut (
        .clk   (clk),
        .reset (reset),
        .arr_a (arr_a),
        .arr_b (arr_b),
        .la    (la),
        .lb    (lb),
        .ta    (ta),
        .tb    (tb),
        .qa    (qa),
        .qb    (qb),
        .dep_a (dep_a),
        .dep_b (dep_b),
        .ovf_a (ovf_a),
        .ovf_b (ovf_b),
        .err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(input logic rst, input logic aa, input logic ab,
                                 input logic [1:0] la_i, input logic [1:0] lb_i,
                                 input int eqa, input int eqb,
                                 input logic dpa, input logic dpb,
                                 input logic ova, input logic ovb);
        vec_t v;
        v.rst = rst; v.aa = aa; v.ab = ab; v.la = la_i; v.lb = lb_i;
        v.eqa = 4'(eqa); v.eqb = 4'(eqb);
        v.edep_a = dpa; v.edep_b = dpb; v.eovf_a = ova; v.eovf_b = ovb;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one vector, let one edge pass, then compare against the scoreboard head.
    task automatic run_vec(input string tag, input vec_t v);
        vec_t e;
        reset = v.rst; arr_a = v.aa; arr_b = v.ab; la = v.la; lb = v.lb;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, " qa"},    int'(qa),    int'(e.eqa));
            check({tag, " qb"},    int'(qb),    int'(e.eqb));
            check({tag, " ta"},    int'(ta),    int'(e.eqa != 0));
            check({tag, " tb"},    int'(tb),    int'(e.eqb != 0));
            check({tag, " dep_a"}, int'(dep_a), int'(e.edep_a));
            check({tag, " dep_b"}, int'(dep_b), int'(e.edep_b));
            check({tag, " ovf_a"}, int'(ovf_a), int'(e.eovf_a));
            check({tag, " ovf_b"}, int'(ovf_b), int'(e.eovf_b));
        end
    endtask

    initial begin
        reset = 1'b1; arr_a = 1'b0; arr_b = 1'b0; la = R; lb = R;

        //              rst aa ab la lb qa qb dA dB oA oB
        tbl[0]  = mkv(1, 0, 0, R, R, 0, 0, 0, 0, 0, 0);
        // three arrivals on A while red
        tbl[1]  = mkv(0, 1, 0, R, R, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mkv(0, 1, 0, R, R, 2, 0, 0, 0, 0, 0);
        tbl[3]  = mkv(0, 1, 0, R, R, 3, 0, 0, 0, 0, 0);
        // green drains A: departures visible at relative cycles 3, 5, 7
        tbl[4]  = mkv(0, 0, 0, G, R, 3, 0, 0, 0, 0, 0);
        tbl[5]  = mkv(0, 0, 0, G, R, 3, 0, 0, 0, 0, 0);
        tbl[6]  = mkv(0, 0, 0, G, R, 2, 0, 1, 0, 0, 0);
        tbl[7]  = mkv(0, 0, 0, G, R, 2, 0, 0, 0, 0, 0);
        tbl[8]  = mkv(0, 0, 0, G, R, 1, 0, 1, 0, 0, 0);
        tbl[9]  = mkv(0, 0, 0, G, R, 1, 0, 0, 0, 0, 0);
        tbl[10] = mkv(0, 0, 0, G, R, 0, 0, 1, 0, 0, 0);
        tbl[11] = mkv(0, 0, 0, G, R, 0, 0, 0, 0, 0, 0);
        // aborted crossing, then a fresh full crossing from IDLE
        tbl[12] = mkv(0, 1, 0, Y, R, 1, 0, 0, 0, 0, 0);
        tbl[13] = mkv(0, 0, 0, G, R, 1, 0, 0, 0, 0, 0);
        tbl[14] = mkv(0, 0, 0, Y, R, 1, 0, 0, 0, 0, 0);
        tbl[15] = mkv(0, 0, 0, Y, R, 1, 0, 0, 0, 0, 0);
        tbl[16] = mkv(0, 0, 0, R, R, 1, 0, 0, 0, 0, 0);
        tbl[17] = mkv(0, 0, 0, G, R, 1, 0, 0, 0, 0, 0);
        tbl[18] = mkv(0, 0, 0, G, R, 1, 0, 0, 0, 0, 0);
        tbl[19] = mkv(0, 0, 0, G, R, 0, 0, 1, 0, 0, 0);
        // reset the cycle before B's scheduled departure
        tbl[20] = mkv(0, 0, 1, Y, R, 0, 1, 0, 0, 0, 0);
        tbl[21] = mkv(0, 0, 0, R, G, 0, 1, 0, 0, 0, 0);
        tbl[22] = mkv(0, 0, 0, R, G, 0, 1, 0, 0, 0, 0);
        tbl[23] = mkv(1, 0, 0, R, G, 0, 0, 0, 0, 0, 0);
        tbl[24] = mkv(0, 0, 0, R, R, 0, 0, 0, 0, 0, 0);
        // both streets depart in the same cycle
        tbl[25] = mkv(0, 1, 1, R, R, 1, 1, 0, 0, 0, 0);
        tbl[26] = mkv(0, 0, 0, G, G, 1, 1, 0, 0, 0, 0);
        tbl[27] = mkv(0, 0, 0, G, G, 1, 1, 0, 0, 0, 0);
        tbl[28] = mkv(0, 0, 0, G, G, 0, 0, 1, 1, 0, 0);
        tbl[29] = mkv(1, 0, 0, R, R, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 30; i++)
            run_vec($sformatf("v%0d", i), tbl[i]);
        check("reset err", int'(err), 0);

        // Overflow: fill A to 15, drop one arrival, then arrive during a departure.
        run_vec("ovf_rst", mkv(1, 0, 0, R, R, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 15; i++)
            run_vec($sformatf("fill%0d", i), mkv(0, 1, 0, R, R, i, 0, 0, 0, 0, 0));
        run_vec("ovf_drop",  mkv(0, 1, 0, R, R, 15, 0, 0, 0, 1, 0));
        run_vec("ovf_g0",    mkv(0, 0, 0, G, R, 15, 0, 0, 0, 1, 0));
        run_vec("ovf_g1",    mkv(0, 0, 0, G, R, 15, 0, 0, 0, 1, 0));
        run_vec("ovf_depar", mkv(0, 1, 0, G, R, 15, 0, 1, 0, 1, 0));
        run_vec("ovf_yel",   mkv(0, 0, 0, Y, R, 15, 0, 0, 0, 1, 0));
        run_vec("ovf_red",   mkv(0, 0, 0, R, R, 15, 0, 0, 0, 1, 0));

        // Safety monitor: both non-red, then GREEN->RED skipping YELLOW.
        run_vec("err_rst0", mkv(1, 0, 0, R, R, 0, 0, 0, 0, 0, 0));
        check("err after reset", int'(err), 0);
        run_vec("err_gy", mkv(0, 0, 0, G, Y, 0, 0, 0, 0, 0, 0));
        check("err both non-red", int'(err), int'(EXP_ERR));
        run_vec("err_yr", mkv(0, 0, 0, Y, R, 0, 0, 0, 0, 0, 0));
        check("err sticky", int'(err), int'(EXP_ERR));
        run_vec("err_rst1", mkv(1, 0, 0, R, R, 0, 0, 0, 0, 0, 0));
        check("err cleared by reset", int'(err), 0);
        run_vec("err_g", mkv(0, 0, 0, G, R, 0, 0, 0, 0, 0, 0));
        check("err legal red->green", int'(err), 0);
        run_vec("err_gr", mkv(0, 0, 0, R, R, 0, 0, 0, 0, 0, 0));
        check("err green->red", int'(err), int'(EXP_ERR));
        run_vec("err_hold", mkv(0, 0, 0, R, R, 0, 0, 0, 0, 0, 0));
        check("err green->red sticky", int'(err), int'(EXP_ERR));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/traffic_sensor.md
# traffic_sensor

Intersection environment model for the two-street traffic-light controller. It sits on the far side of the light interface. It consumes light codes `la`/`lb`, keeps per-street car queues fed by arrival pulses, and retires cars while their street is green. It drives the traffic-sensor outputs `ta`/`tb` back to the controller. An optional monitor flags unsafe light sequences, making the block usable for closed-loop simulation and on-board demos.

## Interface
Parameters:
- `QW`, default 4: queue counter width; max queue = 2^QW-1.
- `DWELL`, default 2: green cycles one car needs to cross (≥1).

Ports:
- `clk`  in  1  clock; one clock domain, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `arr_a`, `arr_b`  in  1  one car arrives on street A/B this cycle.
- `la`, `lb`  in  2  light codes: GREEN=2'b00, YELLOW=2'b01, RED=2'b10; 2'b11 illegal.
- `ta`, `tb`  out  1  traffic present on street A/B.
- `qa`, `qb`  out  QW  current queue length.
- `dep_a`, `dep_b`  out  1  one-cycle pulse, a car departed.
- `ovf_a`, `ovf_b`  out  1  sticky, an arrival was dropped at full queue.
- `err`  out  1  sticky safety violation; tied 0 without the monitor.

## Operation
- Reset values: `qa`=`qb`=0, `ta`=`tb`=0, `dep_*`=0, `ovf_*`=0, `err`=0, both departure FSMs IDLE.
- Queue update per street, all registered:
  - arrival only → q+1;
  - departure only → q-1;
  - both → q unchanged;
  - arrival at q=max with no departure → q held and ovf set.
- `ta` = (`qa`≠0), `tb` = (`qb`≠0). Both are combinational from the registered counts.
- Departure FSM per street, states IDLE and CROSS, with cycle counter `cnt`:
  - IDLE: light==GREEN and q≠0 → CROSS, cnt=0.
  - CROSS, light≠GREEN → IDLE with no departure; the crossing is aborted and the car stays queued.
  - CROSS, GREEN, cnt<DWELL-1 → cnt+1.
  - CROSS, GREEN, cnt==DWELL-1 → register dep=1 and decrement q. Go to CROSS with cnt=0 if the post-update q≠0, else go to IDLE.
- Illegal light code 2'b11 is treated as non-GREEN.
- Streets are fully independent. Both may depart in the same cycle.
- Reset during CROSS aborts the crossing with no `dep` pulse. Queues clear to 0.

## Timing
- Arrival in cycle n → q and `ta` updated in cycle n+1.
- Street green with q≠0 first sampled in cycle n → `dep` high and q decremented in cycle n+DWELL+1.
- Back-to-back departures occur every DWELL cycles while green and q≠0.
- `dep` pulses last exactly one cycle. Their timing coincides with the cycle q shows the decremented value.
- `ovf` and `err` are set one cycle after the offending sample. They clear only on reset.

## Configuration
- Macro `TRAFFIC_SENSOR_CHECK_EN`.
- Defined: a monitor registers the previous `la`/`lb` and sets `err` when any of these holds:
  - both lights are non-RED in the same cycle;
  - either light is 2'b11;
  - either light goes GREEN→RED directly, skipping YELLOW;
  - either light goes RED→YELLOW.
- Undefined: the monitor and its previous-light registers are not compiled; `err` is constant 0.

## Structure
- Package `traffic_pkg`:
  - `light_t` enum (GREEN, YELLOW, RED) with the 2-bit encoding above;
  - departure state enum (IDLE, CROSS).
- Sub-module `street_queue`, instantiated twice:
  - holds counter, departure FSM, `ovf`;
  - ports: `clk`, `reset`, `arr`, `light`, `q`, `t`, `dep`, `ovf`.
- The top holds the two instances and the optional monitor.

## Test plan
- Reset, then 3 `arr_a` pulses on consecutive cycles with `la`=RED → `qa` reads 1, 2, 3; `ta`=1 from the cycle after the first pulse; no `dep_a`.
- `qa`=3, `la` set GREEN at cycle 0, DWELL=2 → `dep_a` pulses at cycles 3, 5, 7; `qa` steps 2, 1, 0; `ta` falls at cycle 7.
- `qa`=1, GREEN for 1 cycle then YELLOW → no `dep_a`; `qa` stays 1; FSM returns to IDLE.
- `qa`=15 (QW=4), `arr_a` with `la`=RED → `qa` stays 15, `ovf_a`=1 next cycle. Then, with `la`=GREEN, an `arr_a` in the cycle `dep_a` asserts → `qa` stays 15.
- Reset asserted in the cycle before a scheduled `dep_b` → `dep_b` never pulses; all outputs 0 next cycle.
- Macro defined: `la`=GREEN and `lb`=YELLOW together, or `la` GREEN→RED → `err`=1 next cycle and stays 1. Macro undefined: same stimulus → `err`=0.
